// File: rtl/hazard_ctrl_if.sv
// Hazard-controller signal bundle: pipeline status into the controller, pipeline controls out.
// The pipeline side is the master; the controller is the slave.
interface hazard_ctrl_if;
    logic [4:0] ID_Rs;
    logic [4:0] ID_Rt;
    logic       ID_UsesRt;
    logic       ID_Jump;
    logic       EX_MemRead;
    logic [4:0] EX_Rt;
    logic       EX_BranchTaken;
    logic       MemBusy;
    logic       Irq;
    logic       IrqEnable;
    logic       PCWrite;
    logic       IF_ID_Write;
    logic       IF_ID_Flush;
    logic       ID_EX_Flush;
    logic       PipeHold;
    logic       EPCWrite;
    logic       ExcPCSel;
    logic       IrqAck;
    logic [1:0] State;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, ID_Jump, EX_MemRead, EX_Rt,
               EX_BranchTaken, MemBusy, Irq, IrqEnable,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PipeHold,
               EPCWrite, ExcPCSel, IrqAck, State
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, ID_Jump, EX_MemRead, EX_Rt,
               EX_BranchTaken, MemBusy, Irq, IrqEnable,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PipeHold,
               EPCWrite, ExcPCSel, IrqAck, State
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stalls, flushes, memory freezes
// and the drain/vector sequence that enters the exception handler on an enabled interrupt.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    hazard_ctrl_if.slave hz
);

    localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_VECTOR = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             irq_block_r;
    logic             irq_block_s;

    logic load_use_s;
    logic irq_take_s;
    logic pc_write_s;
    logic ifid_write_s;
    logic ifid_flush_n_s;
    logic idex_flush_n_s;
    logic pipe_hold_s;
    logic epc_write_s;
    logic exc_sel_s;
    logic irq_ack_s;

    // The load's destination must be a real register; r0 never creates a dependency.
    assign load_use_s = hz.EX_MemRead && (hz.EX_Rt != 5'd0) &&
                        ((hz.EX_Rt == hz.ID_Rs) || (hz.ID_UsesRt && (hz.EX_Rt == hz.ID_Rt)));

    assign irq_take_s = hz.Irq && hz.IrqEnable && !irq_block_r && !hz.MemBusy &&
                        !hz.EX_BranchTaken && !load_use_s;

    // Sequencer state, drain counter and the one-cycle interrupt lockout after VECTOR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_RUN;
            cnt_r       <= CNT_ZERO;
            irq_block_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            irq_block_r <= irq_block_s;
        end
    end

    // Next-state and pipeline control decode; reset forces the quiescent control values.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        irq_block_s    = 1'b0;
        pc_write_s     = 1'b0;
        ifid_write_s   = 1'b0;
        ifid_flush_n_s = 1'b1;
        idex_flush_n_s = 1'b1;
        pipe_hold_s    = 1'b0;
        epc_write_s    = 1'b0;
        exc_sel_s      = 1'b0;
        irq_ack_s      = 1'b0;
        if (reset) begin
            state_s = ST_RUN;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (hz.MemBusy) begin
                        pipe_hold_s = 1'b1;
                    end else if (hz.EX_BranchTaken) begin
                        pc_write_s     = 1'b1;
                        ifid_write_s   = 1'b1;
                        ifid_flush_n_s = 1'b0;
                        idex_flush_n_s = 1'b0;
                    end else if (load_use_s) begin
                        idex_flush_n_s = 1'b0;
                    end else if (irq_take_s) begin
                        // A jump in ID is squashed here so EPC captures the jump's own PC.
                        epc_write_s    = 1'b1;
                        ifid_flush_n_s = 1'b0;
                        idex_flush_n_s = 1'b0;
                        state_s        = ST_DRAIN;
                        cnt_s          = CNT_LOAD;
                    end else if (hz.ID_Jump) begin
                        pc_write_s     = 1'b1;
                        ifid_write_s   = 1'b1;
                        ifid_flush_n_s = 1'b0;
                    end else begin
                        pc_write_s   = 1'b1;
                        ifid_write_s = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    ifid_flush_n_s = 1'b0;
                    idex_flush_n_s = 1'b0;
                    if (hz.MemBusy) begin
                        pipe_hold_s = 1'b1;
                    end else if (cnt_r == CNT_ZERO) begin
                        state_s = ST_VECTOR;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end
                ST_VECTOR: begin
                    pc_write_s     = 1'b1;
                    exc_sel_s      = 1'b1;
                    irq_ack_s      = 1'b1;
                    ifid_flush_n_s = 1'b0;
                    state_s        = ST_RUN;
                    cnt_s          = CNT_ZERO;
                    irq_block_s    = 1'b1;
                end
                default: begin
                    state_s = ST_RUN;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    assign hz.PCWrite     = pc_write_s;
    assign hz.IF_ID_Write = ifid_write_s;
    assign hz.IF_ID_Flush = ifid_flush_n_s;
    assign hz.ID_EX_Flush = idex_flush_n_s;
    assign hz.PipeHold    = pipe_hold_s;
    assign hz.EPCWrite    = epc_write_s;
    assign hz.ExcPCSel    = exc_sel_s;
    assign hz.IrqAck      = irq_ack_s;
    assign hz.State       = state_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic, checked each cycle
// against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int DC = 2;

    logic clk = 1'b0;
    logic reset;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.DRAIN_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    always #5 clk = ~clk;

    // Output vector bit order: PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
    // PipeHold, EPCWrite, ExcPCSel, IrqAck.
    localparam logic [7:0] M_ALL = 8'hFF;
    localparam logic [7:0] M_IFW = 8'b0100_0000;
    localparam logic [7:0] M_IFF = 8'b0010_0000;
    localparam logic [7:0] M_IEF = 8'b0001_0000;

    typedef struct {
        logic [7:0] val;
        logic [7:0] mask;
        logic [1:0] st;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: 0 = running, 1 = draining, 2 = vectoring.
    int m_state = 0;
    int m_left  = 0;
    bit m_block = 1'b0;

    task automatic set_inputs(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                              input logic jump, input logic memrd, input logic [4:0] ert,
                              input logic br, input logic busy, input logic irq, input logic en);
        hz.ID_Rs          = rs;
        hz.ID_Rt          = rt;
        hz.ID_UsesRt      = uses;
        hz.ID_Jump        = jump;
        hz.EX_MemRead     = memrd;
        hz.EX_Rt          = ert;
        hz.EX_BranchTaken = br;
        hz.MemBusy        = busy;
        hz.Irq            = irq;
        hz.IrqEnable      = en;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic jump, input logic memrd, input logic [4:0] ert,
                         input logic br, input logic busy, input logic irq, input logic en);
        exp_t e;
        bit   lu;
        bit   take;
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_inputs(rs, rt, uses, jump, memrd, ert, br, busy, irq, en);
        lu   = memrd && (ert != 5'd0) && ((ert == rs) || (uses && (ert == rt)));
        take = (m_state == 0) && !m_block && irq && en && !busy && !br && !lu;
        e.st = 2'(m_state);
        if (m_state == 0) begin
            if (busy) begin
                e.val = 8'b0011_1000; e.mask = M_ALL; e.name = "freeze";
            end else if (br) begin
                e.val = 8'b1000_0000; e.mask = M_ALL & ~M_IFW; e.name = "branch";
            end else if (lu) begin
                e.val = 8'b0000_0000; e.mask = M_ALL & ~M_IFF; e.name = "load_use";
            end else if (take) begin
                e.val = 8'b0000_0100; e.mask = M_ALL & ~M_IFW; e.name = "irq_entry";
            end else if (jump) begin
                e.val = 8'b1000_0000; e.mask = M_ALL & ~M_IFW & ~M_IEF; e.name = "jump";
            end else begin
                e.val = 8'b1111_0000; e.mask = M_ALL; e.name = "run";
            end
        end else if (m_state == 1) begin
            e.val = {4'b0000, busy, 3'b000}; e.mask = M_ALL & ~M_IFW; e.name = "drain";
        end else begin
            e.val = 8'b1000_0011; e.mask = M_ALL & ~M_IFW & ~M_IEF; e.name = "vector";
        end
        sb_q.push_back(e);
        case (m_state)
            0: begin
                if (take) begin
                    m_state = 1;
                    m_left  = DC;
                end
                m_block = 1'b0;
            end
            1: begin
                if (!busy) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_state = 2;
                end
            end
            default: begin
                m_state = 0;
                m_block = 1'b1;
            end
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset is raised 1 time unit after the edge; the check lands before the next edge.
    task automatic do_reset();
        exp_t e;
        @(posedge clk);
        #1;
        set_inputs(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset  = 1'b1;
        e.val  = 8'b0011_0000;
        e.mask = M_ALL;
        e.st   = 2'd0;
        e.name = "reset";
        sb_q.push_back(e);
        m_state = 0;
        m_left  = 0;
        m_block = 1'b0;
    endtask

    // Monitor: one scoreboard entry per cycle, compared at the falling edge.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {hz.PCWrite, hz.IF_ID_Write, hz.IF_ID_Flush, hz.ID_EX_Flush,
                       hz.PipeHold, hz.EPCWrite, hz.ExcPCSel, hz.IrqAck};
                checks++;
                if ((((act ^ e.val) & e.mask) !== 8'd0) || (hz.State !== e.st)) begin
                    errors++;
                    $display("FAIL %s @%0t: got out=%b state=%0d, want out=%b (mask %b) state=%0d",
                             e.name, $time, act, hz.State, e.val, e.mask, e.st);
                end
            end
        end
    end

    initial begin
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] ert;
        reset = 1'b1;
        set_inputs(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        do_reset();
        idle(3);
        do_reset();
        idle(2);

        // Load-use stall, r0 destination, rt path with and without ID_UsesRt.
        drive(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        drive(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(5'd1, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        // Branch together with load-use, then MemBusy together with branch.
        drive(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single-cycle interrupt, then Irq held high across two entries.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(5);
        for (int i = 0; i < 10; i++) drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);
        // Disabled interrupt is ignored.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Entry, then three MemBusy cycles inside DRAIN.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        // Jump together with Irq.
        drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(5);
        // Reset in the middle of DRAIN and in the middle of VECTOR.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1);
        do_reset();
        idle(3);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);
        do_reset();
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                rs = 5'($urandom_range(0, 31));
                rt = 5'($urandom_range(0, 31));
                case ($urandom_range(0, 3))
                    0:       ert = 5'd0;
                    1:       ert = rs;
                    2:       ert = rt;
                    default: ert = 5'($urandom_range(0, 31));
                endcase
                drive(rs, rt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 1)), ert, 1'($urandom_range(0, 5) == 0),
                      1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 3) != 0));
            end
        end

        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: got %0d pending entries, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
